// File: rtl/divider_pkg.sv
// Shared widths and state encoding for the sequential restoring divider.
package divider_pkg;

   localparam int unsigned NUM_W = 8;
   localparam int unsigned DEN_W = 4;
   localparam int unsigned CNT_W = $clog2(NUM_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module divider_step
   import divider_pkg::*;
(
   input  logic [DEN_W:0]   p,
   input  logic             bit_in,
   input  logic [DEN_W-1:0] d,
   output logic [DEN_W:0]   p_nx,
   output logic             qbit
);

   logic [DEN_W+1:0] t;

   // p < d always holds, so p[DEN_W] is zero and the extra top bit of t is the borrow
   always_comb begin
      t    = {p, bit_in} - (DEN_W+2)'(d);
      qbit = ~t[DEN_W+1];
      p_nx = qbit ? t[DEN_W:0] : {p[DEN_W-1:0], bit_in};
   end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider: NUM_W-bit dividend by DEN_W-bit divisor, start/done handshake.
module divider
   import divider_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic [NUM_W-1:0] dividend,
   input  logic [DEN_W-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [NUM_W-1:0] quotient,
   output logic [DEN_W-1:0] remainder,
   output logic             div_zero
);

   state_t           state, state_nx;
   logic [CNT_W-1:0] count;
   logic [NUM_W-1:0] q_sh;
   logic [DEN_W:0]   p, p_nx;
   logic [DEN_W-1:0] d_r;
   logic             qbit;
   logic             accept;
   logic             last;

   divider_step u_step (
      .p      (p),
      .bit_in (q_sh[NUM_W-1]),
      .d      (d_r),
      .p_nx   (p_nx),
      .qbit   (qbit)
   );

   // Next-state decode
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (count == CNT_W'(NUM_W-1)) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, datapath and output registers; enable freezes everything
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ready     <= 1'b1;
         done      <= 1'b0;
         count     <= '0;
         q_sh      <= '0;
         p         <= '0;
         d_r       <= '0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else if (enable) begin
         state <= state_nx;
         ready <= (state_nx == IDLE);
         done  <= (state_nx == DONE);
         if (accept) begin
            q_sh  <= dividend;
            d_r   <= divisor;
            p     <= '0;
            count <= '0;
            if (divisor == '0) begin
               quotient  <= '1;
               remainder <= dividend[DEN_W-1:0];
               div_zero  <= 1'b1;
            end
         end else if (state == RUN) begin
            p     <= p_nx;
            q_sh  <= {q_sh[NUM_W-2:0], qbit};
            count <= count + CNT_W'(1);
            // Results take the final step's outputs, not the pre-step registers
            if (last) begin
               quotient  <= {q_sh[NUM_W-2:0], qbit};
               remainder <= p_nx[DEN_W-1:0];
               div_zero  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_divider.sv
// Directed and sweep bench for the sequential divider.
module tb_divider;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic       ready, done, div_zero;
   logic [7:0] quotient;
   logic [3:0] remainder;

   int checks = 0;
   int failures = 0;

   divider dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .ready     (ready),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one division and check latency (edges from acceptance, inclusive) and results
   task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic ez,
                          input int elat, input bit poke, input int stall_at);
      int lat;
      lat = 0;
      while (!ready && lat < 50) begin
         tick();
         lat++;
      end
      if (!ready) check({tag, "_ready_timeout"}, ready, 1);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      lat   = 1;
      start = poke;
      if (poke) begin
         dividend = ~a;
         divisor  = b + 4'd3;
         check({tag, "_busy_ready"}, ready, 0);
      end
      while (!done && lat < 40) begin
         if (stall_at != 0 && lat == stall_at) begin
            enable = 1'b0;
            repeat (5) tick();
            lat   += 5;
            enable = 1'b1;
         end
         tick();
         lat++;
      end
      start = 1'b0;
      check({tag, "_latency"}, lat, elat);
      check({tag, "_q"}, quotient, eq);
      check({tag, "_r"}, remainder, er);
      check({tag, "_dz"}, div_zero, ez);
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_dz", div_zero, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      run_div("t1_143_11", 8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 9, 1'b0, 0);
      tick();
      check("t1_ready_after", ready, 1);
      check("t1_done_low", done, 0);

      run_div("t2_200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9, 1'b0, 0);
      run_div("t2_255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9, 1'b0, 0);
      run_div("t2_5_15", 8'd5, 4'd15, 8'd0, 4'd5, 1'b0, 9, 1'b0, 0);

      run_div("t3_77_0", 8'd77, 4'd0, 8'hFF, 4'hD, 1'b1, 1, 1'b0, 0);
      run_div("t3_100_3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9, 1'b0, 0);

      run_div("t4_busy_start", 8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 9, 1'b1, 0);

      run_div("t5_stall", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 14, 1'b0, 4);

      // done pulse stretches while enable is low
      run_div("t5b_hold", 8'd60, 4'd7, 8'd8, 4'd4, 1'b0, 9, 1'b0, 0);
      enable = 1'b0;
      tick();
      tick();
      check("t5b_done_held", done, 1);
      check("t5b_ready_held", ready, 0);
      enable = 1'b1;
      tick();
      check("t5b_done_drop", done, 0);

      // asynchronous reset in the middle of a run
      dividend = 8'd143;
      divisor  = 4'd11;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("t6_busy", ready, 0);
      #2 reset = 1'b1;
      #1;
      check("t6_ready", ready, 1);
      check("t6_done", done, 0);
      check("t6_q", quotient, 0);
      check("t6_r", remainder, 0);
      reset = 1'b0;
      tick();
      run_div("t6_60_4", 8'd60, 4'd4, 8'd15, 4'd0, 1'b0, 9, 1'b0, 0);

      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            run_div("sweep", 8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 9, 1'b0, 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
